// File: rtl/usb_tx_scheduler.sv
// usb_tx_scheduler: two-requester round-robin packet scheduler feeding a
// byte-wide TX engine through a tx_start/tx_done handshake.
// Optional USB CRC16 trailer is enabled by defining USB_TX_SCHED_CRC16_EN;
// the default build carries no CRC logic and ends packets after the last byte.

module usb_tx_scheduler (
    input  logic       clk,
    input  logic       RST,
    input  logic [1:0] req_valid,
    input  logic [7:0] req_data0,
    input  logic [7:0] req_data1,
    input  logic [1:0] req_last,
    output logic [1:0] req_ack,
    output logic       tx_start,
    output logic [7:0] tx_data_in,
    input  logic       tx_done,
    output logic       busy,
    output logic [1:0] grant,
    output logic       pkt_done
);

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        ISSUE,
        WAIT,
        CRC_LO,
        CRC_HI,
        FIN
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_owner;
    logic        r_last_owner;
    logic [1:0]  r_grant;
    logic        r_last;
    logic [7:0]  r_tx_data;

    logic        w_pick;
    logic [1:0]  w_arb_grant;
    logic        w_owner_valid;
    logic [7:0]  w_owner_data;
    logic        w_owner_last;

    logic        w_start;
    logic [7:0]  w_byte;
    logic [1:0]  w_ack;
    logic        w_pkt_done;

`ifdef USB_TX_SCHED_CRC16_EN
    logic [15:0] r_crc;
    logic        r_crc_sent;
    logic        r_is_pid;

    // Reflected CRC16 (poly 0x8005 -> 0xA001), one data byte, LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in,
                                               input logic [7:0]  data);
        logic [15:0] c;
        logic [7:0]  b;
        c = crc_in;
        b = data;
        for (int unsigned i = 0; i < 8; i++) begin
            if (c[0] ^ b[0]) begin
                c = (c >> 1) ^ 16'hA001;
            end else begin
                c = c >> 1;
            end
            b = b >> 1;
        end
        return c;
    endfunction
`endif

    // Round-robin pick: on a tie the requester that did not own the last packet wins.
    always_comb begin
        w_pick      = (req_valid == 2'b11) ? ~r_last_owner : req_valid[1];
        w_arb_grant = '0;
        if (|req_valid) begin
            w_arb_grant = w_pick ? 2'b10 : 2'b01;
        end
    end

    // Owner-side view of the requester interface.
    always_comb begin
        w_owner_valid = req_valid[r_owner];
        w_owner_last  = req_last[r_owner];
        w_owner_data  = r_owner ? req_data1 : req_data0;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and pulse outputs; tx_start/req_ack are issued in the same
    // cycle the FSM sits in ISSUE (or an unsent CRC state) so that a tx_done in
    // cycle N yields the next tx_start in cycle N+1.
    always_comb begin
        w_next     = r_state;
        w_start    = 1'b0;
        w_byte     = r_tx_data;
        w_ack      = '0;
        w_pkt_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (|req_valid) begin
                    w_next = ARB;
                end
            end
            ARB: begin
                w_next = (|req_valid) ? ISSUE : IDLE;
            end
            ISSUE: begin
                if (w_owner_valid) begin
                    w_start = 1'b1;
                    w_byte  = w_owner_data;
                    w_ack   = r_owner ? 2'b10 : 2'b01;
                    w_next  = WAIT;
                end
            end
            WAIT: begin
                if (tx_done) begin
                    if (!r_last) begin
                        w_next = ISSUE;
                    end else begin
`ifdef USB_TX_SCHED_CRC16_EN
                        w_next = CRC_LO;
`else
                        w_next = FIN;
`endif
                    end
                end
            end
`ifdef USB_TX_SCHED_CRC16_EN
            CRC_LO: begin
                if (!r_crc_sent) begin
                    w_start = 1'b1;
                    w_byte  = ~r_crc[7:0];
                end else if (tx_done) begin
                    w_next = CRC_HI;
                end
            end
            CRC_HI: begin
                if (!r_crc_sent) begin
                    w_start = 1'b1;
                    w_byte  = ~r_crc[15:8];
                end else if (tx_done) begin
                    w_next = FIN;
                end
            end
`endif
            FIN: begin
                w_pkt_done = 1'b1;
                w_next     = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Packet context: owner, grant, last flag, held TX byte and CRC accumulator.
    always_ff @(posedge clk) begin
        if (RST) begin
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;
            r_grant      <= '0;
            r_last       <= 1'b0;
            r_tx_data    <= '0;
`ifdef USB_TX_SCHED_CRC16_EN
            r_crc        <= '1;
            r_crc_sent   <= 1'b0;
            r_is_pid     <= 1'b0;
`endif
        end else begin
            if (w_start) begin
                r_tx_data <= w_byte;
            end
            case (r_state)
                ARB: begin
                    if (|req_valid) begin
                        r_owner <= w_pick;
                        r_grant <= w_arb_grant;
`ifdef USB_TX_SCHED_CRC16_EN
                        r_crc    <= '1;
                        r_is_pid <= 1'b1;
`endif
                    end
                end
                ISSUE: begin
                    if (w_owner_valid) begin
                        r_last <= w_owner_last;
`ifdef USB_TX_SCHED_CRC16_EN
                        if (!r_is_pid) begin
                            r_crc <= crc16_byte(r_crc, w_owner_data);
                        end
                        r_is_pid <= 1'b0;
`endif
                    end
                end
`ifdef USB_TX_SCHED_CRC16_EN
                CRC_LO, CRC_HI: begin
                    if (w_start) begin
                        r_crc_sent <= 1'b1;
                    end else if (tx_done && r_crc_sent) begin
                        r_crc_sent <= 1'b0;
                    end
                end
`endif
                FIN: begin
                    r_last_owner <= r_owner;
                    r_grant      <= '0;
                    r_last       <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign tx_start   = w_start;
    assign tx_data_in = w_byte;
    assign req_ack    = w_ack;
    assign pkt_done   = w_pkt_done;
    assign busy       = (r_state != IDLE);
    // Grant is visible from the ARB cycle itself and held until FIN exits.
    assign grant      = (r_state == ARB) ? w_arb_grant : r_grant;

endmodule

// File: tb/tb_usb_tx_scheduler.sv
// Self-checking bench for usb_tx_scheduler. Requesters and the TX engine are
// modelled as behavioural processes; expected byte streams come from a
// packet-level model (round-robin order, optional USB CRC16 trailer when
// USB_TX_SCHED_CRC16_EN is defined).

module tb_usb_tx_scheduler;

    logic       clk = 1'b0;
    logic       RST = 1'b1;
    logic [1:0] req_valid;
    logic [7:0] req_data0;
    logic [7:0] req_data1;
    logic [1:0] req_last;
    logic [1:0] req_ack;
    logic       tx_start;
    logic [7:0] tx_data_in;
    logic       tx_done;
    logic       busy;
    logic [1:0] grant;
    logic       pkt_done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    usb_tx_scheduler dut (
        .clk        (clk),
        .RST        (RST),
        .req_valid  (req_valid),
        .req_data0  (req_data0),
        .req_data1  (req_data1),
        .req_last   (req_last),
        .req_ack    (req_ack),
        .tx_start   (tx_start),
        .tx_data_in (tx_data_in),
        .tx_done    (tx_done),
        .busy       (busy),
        .grant      (grant),
        .pkt_done   (pkt_done)
    );

    // ---------------- requester model ----------------
    // entry = {gap_before[7:0], last, data[7:0]}
    logic [16:0] drv_q [2][$];
    int          gap_cnt [2];
    bit          loaded  [2];
    logic [1:0]  ack_s;

    initial begin : drv
        logic       v;
        logic [7:0] d;
        logic       l;
        req_valid = '0;
        req_data0 = '0;
        req_data1 = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            ack_s = req_ack;
            @(posedge clk);
            #1;
            for (int n = 0; n < 2; n++) begin
                if (ack_s[1'(n)] && drv_q[1'(n)].size() > 0) begin
                    void'(drv_q[1'(n)].pop_front());
                    loaded[1'(n)] = 1'b0;
                end
                if (drv_q[1'(n)].size() > 0 && !loaded[1'(n)]) begin
                    gap_cnt[1'(n)] = int'(drv_q[1'(n)][0][16:9]);
                    loaded[1'(n)]  = 1'b1;
                end
                if (drv_q[1'(n)].size() > 0 && gap_cnt[1'(n)] == 0) begin
                    v = 1'b1;
                    d = drv_q[1'(n)][0][7:0];
                    l = drv_q[1'(n)][0][8];
                end else begin
                    v = 1'b0;
                    d = 8'($urandom);
                    l = 1'($urandom);
                    if (gap_cnt[1'(n)] > 0) gap_cnt[1'(n)]--;
                end
                req_valid[1'(n)] = v;
                req_last[1'(n)]  = l;
                if (n == 0) req_data0 = d;
                else        req_data1 = d;
            end
        end
    end

    // ---------------- TX engine model ----------------
    bit eng_en    = 1'b1;
    int eng_fixed = 1;   // 0 selects a random 1..4 cycle latency

    initial begin : eng
        int d;
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (eng_en && !RST && tx_start === 1'b1) begin
                d = (eng_fixed > 0) ? eng_fixed : int'($urandom_range(1, 4));
                repeat (d - 1) @(negedge clk);
                @(posedge clk);
                #1 tx_done = 1'b1;
                @(posedge clk);
                #1 tx_done = 1'b0;
            end
        end
    end

    // ---------------- monitor ----------------
    int         cyc = 0;
    logic [7:0] obs_data  [$];
    logic [1:0] obs_grant [$];
    int         obs_start [$];
    int         obs_done  [$];
    logic [1:0] obs_pkt   [$];
    int         ack_cnt   [2];
    int         viol = 0;
    bit         outstanding = 1'b0;
    logic [7:0] held;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (RST) begin
            outstanding = 1'b0;
        end else begin
            if (tx_start === 1'b1) begin
                if (outstanding) viol++;
                obs_data.push_back(tx_data_in);
                obs_grant.push_back(grant);
                obs_start.push_back(cyc);
                held        = tx_data_in;
                outstanding = 1'b1;
            end else if (outstanding && tx_data_in !== held) begin
                viol++;
            end
            if (tx_done === 1'b1 && outstanding && tx_start !== 1'b1) begin
                obs_done.push_back(cyc);
                outstanding = 1'b0;
            end
            if (pkt_done === 1'b1) obs_pkt.push_back(grant);
            if (req_ack[0] === 1'b1) ack_cnt[0]++;
            if (req_ack[1] === 1'b1) ack_cnt[1]++;
        end
    end

    // ---------------- packet-level reference model ----------------
    logic [7:0] mp_bytes [2][$];
    int         mp_len   [2][$];
    int         m_last_owner = 1;
    logic [7:0] exp_data  [$];
    logic [1:0] exp_grant [$];
    logic [1:0] exp_pkt   [$];
    logic [7:0] pbuf [16];
    int         pgap [16];

    task automatic model_run();
        int         o;
        int         len;
        logic [7:0] b;
        logic [15:0] c;
        logic [1:0] g;
        while (mp_len[0].size() > 0 || mp_len[1].size() > 0) begin
            if (mp_len[0].size() > 0 && mp_len[1].size() > 0) o = (m_last_owner == 0) ? 1 : 0;
            else o = (mp_len[0].size() > 0) ? 0 : 1;
            g   = (o == 1) ? 2'b10 : 2'b01;
            len = mp_len[1'(o)].pop_front();
            c   = 16'hFFFF;
            for (int k = 0; k < len; k++) begin
                b = mp_bytes[1'(o)].pop_front();
                exp_data.push_back(b);
                exp_grant.push_back(g);
                if (k > 0) begin
                    c = c ^ {8'h00, b};
                    repeat (8) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
                end
            end
`ifdef USB_TX_SCHED_CRC16_EN
            c = ~c;
            exp_data.push_back(c[7:0]);
            exp_grant.push_back(g);
            exp_data.push_back(c[15:8]);
            exp_grant.push_back(g);
`endif
            exp_pkt.push_back(g);
            m_last_owner = o;
        end
    endtask

    task automatic add_pkt(input int n, input int len, input bit to_model);
        for (int k = 0; k < len; k++) begin
            drv_q[1'(n)].push_back({8'(pgap[k]), (k == len - 1), pbuf[k]});
            if (to_model) mp_bytes[1'(n)].push_back(pbuf[k]);
        end
        if (to_model) mp_len[1'(n)].push_back(len);
        for (int k = 0; k < 16; k++) pgap[k] = 0;
    endtask

    task automatic clear_logs();
        obs_data.delete();  obs_grant.delete(); obs_start.delete();
        obs_done.delete();  obs_pkt.delete();
        exp_data.delete();  exp_grant.delete(); exp_pkt.delete();
        ack_cnt[0] = 0; ack_cnt[1] = 0; viol = 0;
    endtask

    task automatic flush_drv();
        for (int n = 0; n < 2; n++) begin
            drv_q[1'(n)].delete();
            loaded[1'(n)]  = 1'b0;
            gap_cnt[1'(n)] = 0;
        end
    endtask

    task automatic do_reset();
        flush_drv();
        RST = 1'b1;
        repeat (2) @(posedge clk);
        #1 RST = 1'b0;
        m_last_owner = 1;
    endtask

    task automatic wait_quiet(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (drv_q[0].size() == 0 && drv_q[1].size() == 0 &&
                obs_pkt.size() >= exp_pkt.size() && busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3) @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        flush_drv();
        RST = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (busy !== 1'b0)        begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (grant !== 2'b00)      begin bad++; $display("FAIL reset_grant: got %b want 00", grant); end
        total++; if (tx_start !== 1'b0)    begin bad++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
        total++; if (tx_data_in !== 8'h00) begin bad++; $display("FAIL reset_tx_data: got %h want 00", tx_data_in); end
        total++; if (req_ack !== 2'b00)    begin bad++; $display("FAIL reset_req_ack: got %b want 00", req_ack); end
        total++; if (pkt_done !== 1'b0)    begin bad++; $display("FAIL reset_pkt_done: got %b want 0", pkt_done); end
        @(posedge clk);
        #1 RST = 1'b0;
        m_last_owner = 1;
    endtask

    task automatic test_single_pid();
        bit ok;
        clear_logs();
        pbuf[0] = 8'hC3;
        add_pkt(0, 1, 1'b1);
        model_run();
        wait_quiet(200, ok);
        total++; if (!ok) begin bad++; $display("FAIL single_timeout: busy=%b want idle", busy); end
        total++; if (obs_data.size() != exp_data.size()) begin bad++; $display("FAIL single_count: got %0d bytes want %0d", obs_data.size(), exp_data.size()); end
        for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
            total++;
            if (obs_data[i] !== exp_data[i] || obs_grant[i] !== exp_grant[i]) begin
                bad++; $display("FAIL single_byte%0d: got %h/%b want %h/%b", i, obs_data[i], obs_grant[i], exp_data[i], exp_grant[i]);
            end
        end
        total++; if (obs_pkt.size() != 1) begin bad++; $display("FAIL single_pkt_done: got %0d pulses want 1", obs_pkt.size()); end
    endtask

    task automatic test_round_robin();
        bit ok;
        do_reset();
        clear_logs();
        pbuf[0] = 8'hE1; pbuf[1] = 8'h10; add_pkt(0, 2, 1'b1);
        pbuf[0] = 8'hD2; pbuf[1] = 8'h20; pbuf[2] = 8'h21; add_pkt(0, 3, 1'b1);
        pbuf[0] = 8'h69; pbuf[1] = 8'h30; add_pkt(1, 2, 1'b1);
        model_run();
        wait_quiet(400, ok);
        total++; if (!ok) begin bad++; $display("FAIL rr_timeout: busy=%b want idle", busy); end
        total++; if (obs_pkt.size() != exp_pkt.size()) begin bad++; $display("FAIL rr_pkt_count: got %0d want %0d", obs_pkt.size(), exp_pkt.size()); end
        for (int i = 0; i < exp_pkt.size() && i < obs_pkt.size(); i++) begin
            total++;
            if (obs_pkt[i] !== exp_pkt[i]) begin bad++; $display("FAIL rr_owner%0d: got %b want %b", i, obs_pkt[i], exp_pkt[i]); end
        end
        total++; if (obs_data.size() != exp_data.size()) begin bad++; $display("FAIL rr_count: got %0d bytes want %0d", obs_data.size(), exp_data.size()); end
        for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
            total++;
            if (obs_data[i] !== exp_data[i] || obs_grant[i] !== exp_grant[i]) begin
                bad++; $display("FAIL rr_byte%0d: got %h/%b want %h/%b", i, obs_data[i], obs_grant[i], exp_data[i], exp_grant[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        clear_logs();
        eng_fixed = 1;
        pbuf[0] = 8'h2D; pbuf[1] = 8'h01; pbuf[2] = 8'h02; pbuf[3] = 8'h03;
        add_pkt(0, 4, 1'b1);
        model_run();
        wait_quiet(300, ok);
        total++; if (!ok) begin bad++; $display("FAIL b2b_timeout: busy=%b want idle", busy); end
        total++; if (ack_cnt[0] != 4 || ack_cnt[1] != 0) begin bad++; $display("FAIL b2b_acks: got %0d/%0d want 4/0", ack_cnt[0], ack_cnt[1]); end
        total++; if (obs_data.size() != exp_data.size()) begin bad++; $display("FAIL b2b_count: got %0d starts want %0d", obs_data.size(), exp_data.size()); end
        for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
            total++;
            if (obs_data[i] !== exp_data[i]) begin bad++; $display("FAIL b2b_byte%0d: got %h want %h", i, obs_data[i], exp_data[i]); end
        end
        for (int i = 1; i < obs_start.size() && i <= obs_done.size(); i++) begin
            total++;
            if (obs_start[i] - obs_done[i-1] != 1) begin
                bad++; $display("FAIL b2b_gap%0d: got %0d cycles want 1", i, obs_start[i] - obs_done[i-1]);
            end
        end
        total++; if (viol != 0) begin bad++; $display("FAIL b2b_handshake: got %0d violations want 0", viol); end
    endtask

    task automatic test_stall();
        bit ok;
        clear_logs();
        eng_fixed = 1;
        pbuf[0] = 8'h4B; pbuf[1] = 8'hA0; pbuf[2] = 8'hA1; pbuf[3] = 8'hA2; pbuf[4] = 8'hA3;
        pgap[2] = 10;
        add_pkt(0, 5, 1'b1);
        model_run();
        wait_quiet(400, ok);
        total++; if (!ok) begin bad++; $display("FAIL stall_timeout: busy=%b want idle", busy); end
        total++; if (obs_data.size() != exp_data.size()) begin bad++; $display("FAIL stall_count: got %0d bytes want %0d", obs_data.size(), exp_data.size()); end
        for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
            total++;
            if (obs_data[i] !== exp_data[i] || obs_grant[i] !== exp_grant[i]) begin
                bad++; $display("FAIL stall_byte%0d: got %h/%b want %h/%b", i, obs_data[i], obs_grant[i], exp_data[i], exp_grant[i]);
            end
        end
        if (obs_start.size() >= 3) begin
            total++;
            if (obs_start[2] - obs_start[1] != 11) begin bad++; $display("FAIL stall_resume: got %0d cycles want 11", obs_start[2] - obs_start[1]); end
        end
        total++; if (viol != 0) begin bad++; $display("FAIL stall_handshake: got %0d violations want 0", viol); end
    endtask

    task automatic test_two_byte();
        bit ok;
        clear_logs();
        pbuf[0] = 8'h4B; pbuf[1] = 8'h11;
        add_pkt(1, 2, 1'b1);
        model_run();
        wait_quiet(300, ok);
        total++; if (!ok) begin bad++; $display("FAIL two_timeout: busy=%b want idle", busy); end
`ifdef USB_TX_SCHED_CRC16_EN
        total++; if (obs_start.size() != 4) begin bad++; $display("FAIL two_starts: got %0d want 4", obs_start.size()); end
`else
        total++; if (obs_start.size() != 2) begin bad++; $display("FAIL two_starts: got %0d want 2", obs_start.size()); end
`endif
        for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
            total++;
            if (obs_data[i] !== exp_data[i] || obs_grant[i] !== exp_grant[i]) begin
                bad++; $display("FAIL two_byte%0d: got %h/%b want %h/%b", i, obs_data[i], obs_grant[i], exp_data[i], exp_grant[i]);
            end
        end
        total++; if (obs_pkt.size() != 1) begin bad++; $display("FAIL two_pkt_done: got %0d want 1", obs_pkt.size()); end
    endtask

    task automatic test_reset_mid_crc();
        bit         ok;
        bit         found;
        int         nst;
        int         seen;
        logic [7:0] want;
        clear_logs();
        eng_en = 1'b0;
`ifdef USB_TX_SCHED_CRC16_EN
        nst = 3;
`else
        nst = 2;
`endif
        pbuf[0] = 8'hA5; pbuf[1] = 8'h3C;
        add_pkt(0, 2, 1'b1);
        model_run();
        want = exp_data[nst - 1];
        for (int k = 0; k < nst; k++) begin
            found = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (tx_start === 1'b1) begin found = 1'b1; break; end
            end
            total++; if (!found) begin bad++; $display("FAIL rst_start%0d: got no tx_start want one", k); end
            if (k < nst - 1) begin
                @(posedge clk); #1 tx_done = 1'b1;
                @(posedge clk); #1 tx_done = 1'b0;
            end
        end
        total++; if (tx_data_in !== want) begin bad++; $display("FAIL rst_crc_lo_byte: got %h want %h", tx_data_in, want); end
        @(posedge clk); #1 RST = 1'b1;
        @(posedge clk); #1 RST = 1'b0;
        m_last_owner = 1;
        @(negedge clk);
        total++; if (busy !== 1'b0 || grant !== 2'b00 || tx_start !== 1'b0 || tx_data_in !== 8'h00 || req_ack !== 2'b00 || pkt_done !== 1'b0) begin
            bad++; $display("FAIL rst_outputs: got busy=%b grant=%b start=%b data=%h ack=%b done=%b want all zero", busy, grant, tx_start, tx_data_in, req_ack, pkt_done);
        end
        @(posedge clk); #1 tx_done = 1'b1;
        @(posedge clk); #1 tx_done = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (tx_start !== 1'b0 || busy !== 1'b0) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL rst_late_done: got %0d active cycles want 0", seen); end
        total++; if (obs_pkt.size() != 0) begin bad++; $display("FAIL rst_abort: got %0d pkt_done want 0", obs_pkt.size()); end
        clear_logs();
        eng_en = 1'b1;
        pbuf[0] = 8'hC3; pbuf[1] = 8'h55; add_pkt(1, 2, 1'b1);
        pbuf[0] = 8'h4B; pbuf[1] = 8'h66; add_pkt(0, 2, 1'b1);
        model_run();
        wait_quiet(300, ok);
        total++; if (!ok) begin bad++; $display("FAIL rst_after_timeout: busy=%b want idle", busy); end
        total++; if (obs_pkt.size() != exp_pkt.size()) begin bad++; $display("FAIL rst_after_pkts: got %0d want %0d", obs_pkt.size(), exp_pkt.size()); end
        for (int i = 0; i < exp_pkt.size() && i < obs_pkt.size(); i++) begin
            total++;
            if (obs_pkt[i] !== exp_pkt[i]) begin bad++; $display("FAIL rst_after_owner%0d: got %b want %b", i, obs_pkt[i], exp_pkt[i]); end
        end
        for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
            total++;
            if (obs_data[i] !== exp_data[i]) begin bad++; $display("FAIL rst_after_byte%0d: got %h want %h", i, obs_data[i], exp_data[i]); end
        end
    endtask

    task automatic test_random();
        bit ok;
        int n;
        int len;
        clear_logs();
        eng_fixed = 0;
        for (int p = 0; p < 12; p++) begin
            n   = int'($urandom_range(0, 1));
            len = int'($urandom_range(1, 5));
            for (int k = 0; k < len; k++) begin
                pbuf[k] = 8'($urandom);
                pgap[k] = (k > 0 && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, 4)) : 0;
            end
            add_pkt(n, len, 1'b1);
        end
        model_run();
        wait_quiet(4000, ok);
        total++; if (!ok) begin bad++; $display("FAIL rand_timeout: busy=%b want idle", busy); end
        total++; if (obs_data.size() != exp_data.size()) begin bad++; $display("FAIL rand_count: got %0d bytes want %0d", obs_data.size(), exp_data.size()); end
        for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
            total++;
            if (obs_data[i] !== exp_data[i] || obs_grant[i] !== exp_grant[i]) begin
                bad++; $display("FAIL rand_byte%0d: got %h/%b want %h/%b", i, obs_data[i], obs_grant[i], exp_data[i], exp_grant[i]);
            end
        end
        total++; if (obs_pkt.size() != exp_pkt.size()) begin bad++; $display("FAIL rand_pkts: got %0d want %0d", obs_pkt.size(), exp_pkt.size()); end
        total++; if (viol != 0) begin bad++; $display("FAIL rand_handshake: got %0d violations want 0", viol); end
    endtask

    initial begin
        for (int k = 0; k < 16; k++) pgap[k] = 0;
        test_reset();
        test_single_pid();
        test_round_robin();
        test_back_to_back();
        test_stall();
        test_two_byte();
        test_reset_mid_crc();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/usb_tx_scheduler.md
USB_TX_SCHEDULER -- requirements
Module: usb_tx_scheduler

Interface
REQ-001 The block SHALL have exactly one clock and one reset, with ports as follows:
- clk, input, 1 bit: single clock; all state updates on its rising edge.
- RST, input, 1 bit: reset; synchronous, active-high.
REQ-002 The block SHALL provide these requester ports, n = 0..1:
- req_valid[1:0], input, 2: requester n has a byte pending.
- req_data0/req_data1, input, 8 each: pending byte; the first byte of a packet is the PID.
- req_last[1:0], input, 2: the pending byte is the final byte of the packet.
- req_ack[1:0], output, 2: one-cycle pulse; requester n's byte was consumed.
REQ-003 The block SHALL provide these TX engine ports:
- tx_start, output, 1: one-cycle pulse that starts one byte transmission.
- tx_data_in, output, 8: byte to transmit; held stable from tx_start until tx_done.
- tx_done, input, 1: one-cycle pulse; engine finished the byte.
REQ-004 The block SHALL provide these status ports:
- busy, output, 1: a packet is in progress.
- grant[1:0], output, 2: one-hot owner of the current packet; 0 when idle.
- pkt_done, output, 1: one-cycle pulse after the last byte of a packet, including CRC, completes.

Function
REQ-005 The FSM SHALL have states IDLE, ARB, ISSUE, WAIT, CRC_LO, CRC_HI and FIN.
REQ-006 In IDLE, if any req_valid bit is 1, the FSM SHALL go to ARB on the next cycle; otherwise it SHALL stay in IDLE.
REQ-007 ARB SHALL grant round-robin and last only one cycle:
- If only one requester is valid, grant that requester.
- If both are valid, grant the requester that is not last_owner.
- Then go to ISSUE.
REQ-008 grant SHALL stay constant from ARB until FIN exits; no other requester is served mid-packet.
REQ-009 In ISSUE, if the owner's req_valid is 1, the block SHALL do all of the following in one cycle:
- Latch the owner's req_data into tx_data_in.
- Latch the owner's req_last into an internal last flag.
- Pulse tx_start.
- Pulse the owner's req_ack.
- Go to WAIT.
REQ-010 In ISSUE, if the owner's req_valid is 0, the block SHALL stay in ISSUE with no pulses (requester underrun stall).
REQ-011 In WAIT, when tx_done is seen, the next state SHALL be:
- ISSUE if the last flag is 0.
- CRC_LO if the last flag is 1 and CRC is enabled.
- FIN otherwise.
REQ-012 While waiting for tx_done, the block SHALL NOT pulse tx_start again.
REQ-013 A tx_done that arrives in any state other than WAIT, CRC_LO or CRC_HI SHALL be ignored.
REQ-014 Minimum byte-to-byte overhead SHALL be one cycle: tx_done in cycle N gives tx_start at N+1 when data is valid.
REQ-015 CRC_LO and CRC_HI SHALL each send one byte using the same start/done handshake as ISSUE/WAIT:
- CRC_LO sends the low CRC byte, then goes to CRC_HI on tx_done.
- CRC_HI sends the high byte, then goes to FIN on tx_done.
REQ-016 FIN SHALL do all of the following, then go to IDLE:
- Pulse pkt_done.
- Update last_owner to the current owner.
- Clear grant.
REQ-017 busy SHALL be 1 in every state except IDLE.
REQ-018 A single-byte packet (PID with req_last = 1) SHALL be legal; with CRC enabled it is followed by CRC bytes 0x00, 0x00.
REQ-019 req_valid deasserting mid-packet SHALL stall the block in ISSUE indefinitely; it SHALL NOT abort the packet.

Reset
REQ-020 When RST = 1 at a clk edge, the block SHALL set the following on that edge:
- state = IDLE, last_owner = 1 (so requester 0 wins the first tie).
- grant = 0, tx_start = 0, tx_data_in = 0x00, req_ack = 0, pkt_done = 0, busy = 0.
- CRC register = 0xFFFF, last flag = 0.
REQ-021 Reset asserted mid-packet SHALL abort the packet immediately, and a tx_done arriving after reset SHALL be ignored.

Configuration
REQ-022 The block SHALL use macro USB_TX_SCHED_CRC16_EN to select CRC16 generation.
REQ-023 With USB_TX_SCHED_CRC16_EN defined, the block SHALL generate USB CRC16 as follows:
- Polynomial 0x8005, reflected, init 0xFFFF.
- Computed over every byte after the PID, bits LSB-first.
- Register re-initialised to 0xFFFF in ARB.
- Result transmitted bit-inverted, low byte first.
REQ-024 Without USB_TX_SCHED_CRC16_EN, the block SHALL contain no CRC logic and never enter CRC_LO or CRC_HI; WAIT with the last flag set goes directly to FIN.

Verification
REQ-025 Verification SHALL cover these directed scenarios:
- Single requester, CRC enabled: req0 sends PID 0xC3 then zero data bytes (PID last) -> tx_data_in sequence 0xC3, 0x00, 0x00; one pkt_done; grant = 01 throughout.
- Both requesters valid after reset -> req0 served first, then req1, then req0 again; grant alternates 01, 10, 01.
- req0 packet of 4 bytes with tx_done returned 1 cycle after each tx_start -> tx_start pulses exactly 1 cycle after each tx_done; req_ack count = 4.
- req_valid dropped for 10 cycles after byte 2 -> no tx_start during the gap; packet resumes with byte 3; grant unchanged.
- RST pulsed during CRC_LO -> next cycle all outputs are at reset values; a late tx_done is ignored; the next request goes through ARB normally.
- Build without USB_TX_SCHED_CRC16_EN: PID 0x4B plus data 0x11 -> only 2 tx_start pulses, then pkt_done.
